// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ALU control encoding and immediate extraction
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SRA  = 4'b1111
    } aluctrl_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32I decode into ALU operands and control
// Ports: instr/pc/rs1_data/rs2_data in; op1, op2, aluctrl, rd, regwrite, illegal out.
module alu_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output aluctrl_t    aluctrl,
    output logic [4:0]  rd,
    output logic        regwrite,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       wr_en;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    assign rd     = instr[11:7];
    // Writes to x0 are architecturally discarded; suppress them here.
    assign regwrite = wr_en && (rd != 5'd0);

    // Shared funct3 table for OP and OP-IMM; sub_ok is false for OP-IMM so
    // that ADDI with imm[10] set never turns into SUB.
    function automatic aluctrl_t arith(input logic [2:0] f3, input logic f7, input logic sub_ok);
        case (f3)
            3'b000:  return (sub_ok && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        op1     = 32'd0;
        op2     = 32'd0;
        aluctrl = ALU_ADD;
        wr_en   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP: begin
                op1     = rs1_data;
                op2     = (funct3[1:0] == 2'b01) ? {27'b0, rs2_data[4:0]} : rs2_data;
                aluctrl = arith(funct3, f7b5, 1'b1);
                wr_en   = 1'b1;
            end
            OP_IMM: begin
                op1     = rs1_data;
                op2     = (funct3[1:0] == 2'b01) ? {27'b0, instr[24:20]} : imm_i(instr);
                aluctrl = arith(funct3, f7b5, 1'b0);
                wr_en   = 1'b1;
            end
            LUI: begin
                op2   = imm_u(instr);
                wr_en = 1'b1;
            end
            AUIPC: begin
                op1   = pc;
                op2   = imm_u(instr);
                wr_en = 1'b1;
            end
            LOAD: begin
                op1   = rs1_data;
                op2   = imm_i(instr);
                wr_en = 1'b1;
            end
            STORE: begin
                op1 = rs1_data;
                op2 = imm_s(instr);
            end
            BRANCH: begin
                op1 = rs1_data;
                op2 = rs2_data;
                case (funct3[2:1])
                    2'b10:   aluctrl = ALU_SLT;
                    2'b11:   aluctrl = ALU_SLTU;
                    default: aluctrl = ALU_SUB;
                endcase
            end
            JAL, JALR: begin
                op1   = pc;
                op2   = 32'd4;
                wr_en = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register feeding the execute ALU
// Ports: clk, rst_n; in_* bundle with in_valid/in_ready; flush;
//        out_valid/out_ready with op1, op2, aluctrl, rd, regwrite, illegal.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN_P-1:0] in_pc,
    input  logic [XLEN_P-1:0] in_rs1_data,
    input  logic [XLEN_P-1:0] in_rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN_P-1:0] op1,
    output logic [XLEN_P-1:0] op2,
    output logic [3:0]        aluctrl,
    output logic [4:0]        rd,
    output logic              regwrite,
    output logic              illegal
);

    logic [31:0] op1_d, op2_d;
    aluctrl_t    aluctrl_d;
    logic [4:0]  rd_d;
    logic        regwrite_d, illegal_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] op1_q, op2_q;
    logic [3:0]  aluctrl_q;
    logic [4:0]  rd_q;
    logic        regwrite_q, illegal_q;
    logic        accept, load;

    alu_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .op1      (op1_d),
        .op2      (op2_d),
        .aluctrl  (aluctrl_d),
        .rd       (rd_d),
        .regwrite (regwrite_d),
        .illegal  (illegal_d)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A bundle arriving alongside flush is dropped, so the data registers
    // are not loaded either; out_valid alone carries the kill.
    assign load     = accept && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            aluctrl_q   <= ALU_ADD;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                op1_q      <= op1_d;
                op2_q      <= op2_d;
                aluctrl_q  <= aluctrl_d;
                rd_q       <= rd_d;
                regwrite_q <= regwrite_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign aluctrl   = aluctrl_q;
    assign rd        = rd_q;
    assign regwrite  = regwrite_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] op1, op2;
    logic [3:0]  aluctrl;
    logic [4:0]  rd;
    logic        regwrite, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op1         (op1),
        .op2         (op2),
        .aluctrl     (aluctrl),
        .rd          (rd),
        .regwrite    (regwrite),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ill;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        in_instr    = instr;
        in_pc       = 32'h0000_1000;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_valid    = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            instr         pc            rs1           rs2           op1           op2           ctrl   rd  rw ill
        vecs[0]  = '{32'h002081B3, 32'h0,        32'd5,        32'd7,        32'd5,        32'd7,        4'h0, 5'd3, 1, 0};
        vecs[1]  = '{32'h402081B3, 32'h0,        32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 4'h8, 5'd3, 1, 0};
        vecs[2]  = '{32'h40335293, 32'h0,        32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd3,        4'hF, 5'd5, 1, 0};
        vecs[3]  = '{32'h00000000, 32'h44,       32'h11,       32'h22,       32'h0,        32'h0,        4'h0, 5'd0, 0, 1};
        vecs[4]  = '{32'h00100013, 32'h0,        32'h10,       32'h0,        32'h10,       32'd1,        4'h0, 5'd0, 0, 0};
        vecs[5]  = '{32'h123453B7, 32'h80,       32'hAAAA,     32'h0,        32'h0,        32'h12345000, 4'h0, 5'd7, 1, 0};
        vecs[6]  = '{32'hFFFFF097, 32'h100,      32'h5,        32'h0,        32'h100,      32'hFFFFF000, 4'h0, 5'd1, 1, 0};
        vecs[7]  = '{32'hFE20AE23, 32'h0,        32'h2000,     32'h9,        32'h2000,     32'hFFFFFFFC, 4'h0, 5'd28, 0, 0};
        vecs[8]  = '{32'h0020C463, 32'h0,        32'd3,        32'd9,        32'd3,        32'd9,        4'h2, 5'd8, 0, 0};
        vecs[9]  = '{32'h00209233, 32'h0,        32'h1,        32'h25,       32'h1,        32'd5,        4'h1, 5'd4, 1, 0};
        vecs[10] = '{32'h000000EF, 32'h200,      32'h7,        32'h8,        32'h200,      32'd4,        4'h0, 5'd1, 1, 0};
        vecs[11] = '{32'h0081A283, 32'h0,        32'h300,      32'h0,        32'h300,      32'd8,        4'h0, 5'd5, 1, 0};
        vecs[12] = '{32'h0020B333, 32'h0,        32'h1,        32'h2,        32'h1,        32'h2,        4'h3, 5'd6, 1, 0};
        vecs[13] = '{32'h0020D2B3, 32'h0,        32'hF0,       32'hFFFFFFE4, 32'hF0,       32'd4,        4'h5, 5'd5, 1, 0};
        vecs[14] = '{32'h4020D2B3, 32'h0,        32'hF0,       32'h21,       32'hF0,       32'd1,        4'hF, 5'd5, 1, 0};
        vecs[15] = '{32'h0020F463, 32'h0,        32'h1,        32'h2,        32'h1,        32'h2,        4'h3, 5'd8, 0, 0};
        vecs[16] = '{32'hFFF0C093, 32'h0,        32'h55,       32'h0,        32'h55,       32'hFFFFFFFF, 4'h4, 5'd1, 1, 0};
        vecs[17] = '{32'hC0008093, 32'h0,        32'h55,       32'h0,        32'h55,       32'hFFFFFC00, 4'h0, 5'd1, 1, 0};
        // The in_pc set by drive() is overridden per vector below.

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        #12;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset op1", op1, 32'd0);
        chk("reset aluctrl", {28'b0, aluctrl}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Back-to-back table: in_valid stays high across consecutive vectors.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            in_pc = vecs[i].pc;
            tick();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d op1", i), op1, vecs[i].e_op1);
            chk($sformatf("v%0d op2", i), op2, vecs[i].e_op2);
            chk($sformatf("v%0d aluctrl", i), {28'b0, aluctrl}, {28'b0, vecs[i].e_ctrl});
            chk($sformatf("v%0d rd", i), {27'b0, rd}, {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d regwrite", i), {31'b0, regwrite}, {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].e_ill});
        end
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: hold add for 3 cycles while sub waits upstream.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        chk("bp first valid", {31'b0, out_valid}, 32'd1);
        drive(32'h402081B3, 32'd9, 32'd4);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp hold%0d in_ready", c), {31'b0, in_ready}, 32'd0);
            chk($sformatf("bp hold%0d op1", c), op1, 32'd5);
            chk($sformatf("bp hold%0d aluctrl", c), {28'b0, aluctrl}, 32'h0);
            chk($sformatf("bp hold%0d valid", c), {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp second valid", {31'b0, out_valid}, 32'd1);
        chk("bp second op1", op1, 32'd9);
        chk("bp second aluctrl", {28'b0, aluctrl}, 32'h8);
        tick();
        chk("bp no duplicate", {31'b0, out_valid}, 32'd0);

        // Flush while holding a bundle, with a blt presented the same cycle.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        chk("fl held valid", {31'b0, out_valid}, 32'd1);
        drive(32'h0020C463, 32'd1, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("fl stays empty", {31'b0, out_valid}, 32'd0);
        drive(32'h0020C463, 32'd1, 32'd2);
        tick();
        in_valid = 1'b0;
        chk("fl blt valid", {31'b0, out_valid}, 32'd1);
        chk("fl blt aluctrl", {28'b0, aluctrl}, 32'h2);
        chk("fl blt regwrite", {31'b0, regwrite}, 32'd0);

        // Asynchronous reset while stalled: outputs clear without a clock edge.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        chk("rst pre valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async valid", {31'b0, out_valid}, 32'd0);
        chk("rst async op1", op1, 32'd0);
        chk("rst async op2", op2, 32'd0);
        chk("rst async rd", {27'b0, rd}, 32'd0);
        chk("rst async regwrite", {31'b0, regwrite}, 32'd0);
        chk("rst async in_ready", {31'b0, in_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rst after valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
